// File: rtl/serial_tx_if.sv
// Word handshake between a producer and the serial transmitter.
// The master drives a word and tx_valid; the slave answers with tx_ready.
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// UART-style serialiser: one start bit (0), DATA_W payload bits LSB first, one stop bit (1).
// Every bit lasts CLKS_PER_BIT cycles. A new word is accepted only while idle.
module serial_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_tx_if.slave  tx,
    output logic        tx_out,
    output logic        tx_busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic              tx_out_nxt;
    logic              bit_done;

    assign bit_done = (cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            shreg  <= '0;
            tx_out <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            tx_out <= tx_out_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        cnt_nxt   = (state == IDLE || bit_done) ? '0 : cnt + 1'b1;
        case (state)
            IDLE: begin
                if (tx.tx_valid) begin
                    state_nxt = START;
                    shreg_nxt = tx.tx_data;
                    idx_nxt   = '0;
                end
            end
            START: begin
                if (bit_done) state_nxt = DATA;
            end
            DATA: begin
                // The index holds at its last value; the frame leaves DATA instead of wrapping.
                if (bit_done) begin
                    if (idx == IDX_LAST) begin
                        state_nxt = STOP;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // tx_out is registered from the level the line must carry in the next state.
    always_comb begin
        tx.tx_ready = (state == IDLE);
        tx_busy     = (state != IDLE);
        case (state_nxt)
            START:   tx_out_nxt = 1'b0;
            DATA:    tx_out_nxt = shreg_nxt[0];
            default: tx_out_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: one instance at 4 clocks/bit and one at 1 clock/bit, each
// compared cycle by cycle against a line-level waveform built from the frame format.
module tb_serial_tx;

    logic clk = 1'b0;
    logic rst_n;
    logic out4, busy4, out1, busy1;

    int tests_run    = 0;
    int tests_failed = 0;

    bit exp_out[$];
    bit exp_busy[$];

    serial_tx_if #(.DATA_W(8)) if4 ();
    serial_tx_if #(.DATA_W(8)) if1 ();

    serial_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx      (if4),
        .tx_out  (out4),
        .tx_busy (busy4)
    );

    serial_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx      (if1),
        .tx_out  (out1),
        .tx_busy (busy1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Reference waveform: start bit, payload LSB first, stop bit, each cpb cycles long.
    function automatic void push_frame(input int cpb, input logic [7:0] d);
        for (int c = 0; c < cpb; c++) begin exp_out.push_back(1'b0); exp_busy.push_back(1'b1); end
        for (int b = 0; b < 8; b++)
            for (int c = 0; c < cpb; c++) begin exp_out.push_back(d[b]); exp_busy.push_back(1'b1); end
        for (int c = 0; c < cpb; c++) begin exp_out.push_back(1'b1); exp_busy.push_back(1'b1); end
    endfunction

    function automatic void push_idle(input int n);
        for (int c = 0; c < n; c++) begin exp_out.push_back(1'b1); exp_busy.push_back(1'b0); end
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        if (sel == 0) begin if4.tx_valid = v; if4.tx_data = d; end
        else          begin if1.tx_valid = v; if1.tx_data = d; end
    endtask

    task automatic set_valid(input int sel, input logic v);
        if (sel == 0) if4.tx_valid = v;
        else          if1.tx_valid = v;
    endtask

    // Waits (bounded) for tx_ready, presents the word, and returns #1 after the handshake edge.
    task automatic start_frame(input int sel, input logic [7:0] d);
        int t = 0;
        logic r;
        r = (sel == 0) ? if4.tx_ready : if1.tx_ready;
        while (r !== 1'b1 && t < 200) begin
            @(posedge clk); #1;
            r = (sel == 0) ? if4.tx_ready : if1.tx_ready;
            t++;
        end
        tests_run++;
        if (t >= 200) begin
            tests_failed++;
            $display("FAIL ready_timeout dut%0d: tx_ready got %b want 1 within 200 cycles", sel, r);
        end
        drive(sel, 1'b1, d);
        @(posedge clk); #1;
    endtask

    // Compares the line against the expected queues, one cycle per entry. At cycle at_data the
    // word on tx_data is replaced; at cycle at_drop tx_valid is released.
    task automatic check_stream(input int sel, input string name, input int len,
                                input int at_data, input logic [7:0] new_data, input int at_drop);
        int n;
        logic o, b, r;
        n = (len < 0) ? exp_out.size() : len;
        for (int i = 0; i < n; i++) begin
            o = (sel == 0) ? out4 : out1;
            b = (sel == 0) ? busy4 : busy1;
            r = (sel == 0) ? if4.tx_ready : if1.tx_ready;
            tests_run++;
            if (o !== exp_out[i]) begin
                tests_failed++;
                $display("FAIL %s tx_out cycle %0d: got %b want %b", name, i, o, exp_out[i]);
            end
            tests_run++;
            if (b !== exp_busy[i]) begin
                tests_failed++;
                $display("FAIL %s tx_busy cycle %0d: got %b want %b", name, i, b, exp_busy[i]);
            end
            tests_run++;
            if (r !== !exp_busy[i]) begin
                tests_failed++;
                $display("FAIL %s tx_ready cycle %0d: got %b want %b", name, i, r, !exp_busy[i]);
            end
            if (i == at_data) begin
                if (sel == 0) if4.tx_data = new_data; else if1.tx_data = new_data;
            end
            if (i == at_drop) set_valid(sel, 1'b0);
            @(posedge clk); #1;
        end
        exp_out.delete();
        exp_busy.delete();
    endtask

    task automatic check_idle(input int sel, input string name);
        logic o, b, r;
        o = (sel == 0) ? out4 : out1;
        b = (sel == 0) ? busy4 : busy1;
        r = (sel == 0) ? if4.tx_ready : if1.tx_ready;
        tests_run++;
        if (o !== 1'b1 || b !== 1'b0 || r !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: got out=%b busy=%b ready=%b want out=1 busy=0 ready=1", name, o, b, r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_idle(0, "reset_dut4");
        check_idle(1, "reset_dut1");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle(0, "post_reset_dut4");
    endtask

    // Word presented during reset is refused; the first edge with rst_n=1 takes it.
    task automatic test_first_handshake_cpb1();
        rst_n = 1'b0;
        drive(1, 1'b1, 8'h01);
        @(posedge clk); #1;
        check_idle(1, "no_handshake_in_reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        push_frame(1, 8'h01);
        push_idle(2);
        check_stream(1, "cpb1_first_frame_01", -1, -1, 8'h00, 0);
    endtask

    task automatic test_single_frame();
        start_frame(0, 8'hA5);
        push_frame(4, 8'hA5);
        push_idle(2);
        check_stream(0, "single_A5", -1, -1, 8'h00, 0);
    endtask

    task automatic test_stability();
        start_frame(0, 8'h3C);
        push_frame(4, 8'h3C);
        push_idle(1);
        check_stream(0, "stability_3C", -1, 0, 8'hC3, 0);
    endtask

    task automatic test_back_to_back();
        start_frame(0, 8'h00);
        push_frame(4, 8'h00);
        push_idle(1);
        push_frame(4, 8'hFF);
        push_idle(2);
        check_stream(0, "b2b_00_FF", -1, 0, 8'hFF, 41);
    endtask

    task automatic test_hold_off();
        logic [7:0] d0, d1;
        d0 = 8'($urandom);
        d1 = 8'($urandom);
        start_frame(0, d0);
        push_frame(4, d0);
        push_idle(1);
        push_frame(4, d1);
        push_idle(1);
        check_stream(0, "hold_off", -1, 1, d1, 41);
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        int gap;
        for (int k = 0; k < 6; k++) begin
            d   = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            start_frame(0, d);
            push_frame(4, d);
            push_idle(1 + gap);
            check_stream(0, "random_cpb4", -1, -1, 8'h00, 0);
        end
    endtask

    task automatic test_cpb1_back_to_back();
        logic [7:0] d0, d1;
        for (int k = 0; k < 3; k++) begin
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            start_frame(1, d0);
            push_frame(1, d0);
            push_idle(1);
            push_frame(1, d1);
            push_idle(2);
            check_stream(1, "cpb1_b2b", -1, 0, d1, 11);
        end
    endtask

    // Reset lands in the third cycle of data bit 3; a word offered during reset is ignored.
    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'($urandom) | 8'h08;
        start_frame(0, d);
        push_frame(4, d);
        check_stream(0, "pre_reset_partial", 18, -1, 8'h00, 0);
        rst_n = 1'b0;
        drive(0, 1'b1, 8'h55);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_valid(0, 1'b0);
        check_idle(0, "mid_reset_abort");
        push_idle(6);
        check_stream(0, "after_abort_idle", -1, -1, 8'h00, -1);
        d = 8'($urandom);
        start_frame(0, d);
        push_frame(4, d);
        push_idle(2);
        check_stream(0, "frame_after_reset", -1, -1, 8'h00, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        test_reset();
        test_first_handshake_cpb1();
        test_single_frame();
        test_stability();
        test_back_to_back();
        test_hold_off();
        test_random_frames();
        test_cpb1_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
